// File: rtl/branch_resolver.sv
// branch_resolver: holds in-order branch predictions until they resolve.
// Each resolve is compared with the oldest prediction. The result drives a
// one-cycle training strobe back to the predictor and a mispredict/flush
// pulse. Saturating hit and miss counters and a sticky underflow flag are
// also kept.
module branch_resolver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pred_valid,
  input  logic                     predict,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     upd_valid,
  output logic                     upd_taken,
  output logic                     mispredict,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         hit_cnt,
  output logic [CNT_W-1:0]         miss_cnt,
  output logic                     underflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [AW-1:0]    head_reg, head_next;
  logic [AW-1:0]    tail_reg, tail_next;
  logic [AW:0]      count_reg, count_next;
  logic [DEPTH-1:0] entry_bits;
  logic             upd_valid_reg, upd_taken_reg, mispredict_reg;
  logic [CNT_W-1:0] hit_cnt_reg, miss_cnt_reg;
  logic             underflow_reg;

  logic full, empty, head_bit;
  logic push_ok, pop, miss_pop, hit_pop, push_wr;

  assign full     = (count_reg == FULL_CNT);
  assign empty    = (count_reg == '0);
  assign head_bit = entry_bits[head_reg];
  assign push_ok  = pred_valid && !full;
  assign pop      = res_valid && !empty;
  assign miss_pop = pop && (head_bit != res_taken);
  assign hit_pop  = pop && !miss_pop;
  // A misprediction flushes everything younger, including a same-cycle push.
  assign push_wr  = push_ok && !miss_pop;

  // Storage: one flop per slot, written only when the tail points at it.
  // Slots are not reset; the pointers and count define which ones are live.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
    logic entry_reg;
    // Capture the prediction into this slot on a push at the tail.
    always_ff @(posedge clk) begin
      if (push_wr && (tail_reg == AW'(gi))) begin
        entry_reg <= predict;
      end
    end
    assign entry_bits[gi] = entry_reg;
  end

  // Next pointer/count: a flush empties the FIFO by moving head onto tail.
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (miss_pop) begin
      head_next  = tail_reg;
      count_next = '0;
    end else begin
      if (pop)     head_next = head_reg + 1'b1;
      if (push_wr) tail_next = tail_reg + 1'b1;
      count_next = count_reg + {{AW{1'b0}}, push_wr} - {{AW{1'b0}}, pop};
    end
  end

  // Pointer, status, training and statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      upd_valid_reg  <= 1'b0;
      upd_taken_reg  <= 1'b0;
      mispredict_reg <= 1'b0;
      hit_cnt_reg    <= '0;
      miss_cnt_reg   <= '0;
      underflow_reg  <= 1'b0;
    end else begin
      head_reg       <= head_next;
      tail_reg       <= tail_next;
      count_reg      <= count_next;
      upd_valid_reg  <= pop;
      mispredict_reg <= miss_pop;
      if (pop) upd_taken_reg <= res_taken;
      if (hit_pop && (hit_cnt_reg != '1))   hit_cnt_reg  <= hit_cnt_reg + 1'b1;
      if (miss_pop && (miss_cnt_reg != '1)) miss_cnt_reg <= miss_cnt_reg + 1'b1;
      if (res_valid && empty) underflow_reg <= 1'b1;
    end
  end

  assign pred_ready    = !full;
  assign occupancy     = count_reg;
  assign upd_valid     = upd_valid_reg;
  assign upd_taken     = upd_taken_reg;
  assign mispredict    = mispredict_reg;
  assign hit_cnt       = hit_cnt_reg;
  assign miss_cnt      = miss_cnt_reg;
  assign underflow_err = underflow_reg;

endmodule

// File: tb/tb_branch_resolver.sv
// Testbench for branch_resolver: a hand-derived vector table, a reset
// corner sequence, a saturation sequence, and randomized traffic compared
// against a queue-based reference model.
module tb_branch_resolver;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int OW    = $clog2(DEPTH) + 1;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset, pred_valid, predict, res_valid, res_taken;
  logic pred_ready, upd_valid, upd_taken, mispredict, underflow_err;
  logic [OW-1:0]    occupancy;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  int checks = 0;
  int errors = 0;

  branch_resolver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .predict(predict), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .mispredict(mispredict),
    .occupancy(occupancy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  // Reference model: outstanding predictions as a queue, plus statistics.
  bit m_q[$];
  int m_hit, m_miss;
  bit m_uf, m_uv, m_ut, m_mp;

  task automatic model_step(input bit rst, input bit pv, input bit p, input bit rv, input bit rt);
    bit was_full;
    bit h;
    if (rst) begin
      m_q.delete();
      m_hit = 0; m_miss = 0; m_uf = 0; m_uv = 0; m_ut = 0; m_mp = 0;
      return;
    end
    was_full = (m_q.size() == DEPTH);
    if (rv && m_q.size() == 0) m_uf = 1;
    if (rv && m_q.size() > 0) begin
      h = m_q.pop_front();
      m_uv = 1; m_ut = rt;
      if (h != rt) begin
        m_mp = 1;
        if (m_miss < CMAX) m_miss++;
        m_q.delete();
      end else begin
        m_mp = 0;
        if (m_hit < CMAX) m_hit++;
        if (pv && !was_full) m_q.push_back(p);
      end
    end else begin
      m_uv = 0; m_mp = 0;
      if (pv && !was_full) m_q.push_back(p);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, sample 1ns after the edge.
  task automatic drive(input bit rst, input bit pv, input bit p, input bit rv, input bit rt);
    reset = rst; pred_valid = pv; predict = p; res_valid = rv; res_taken = rt;
    @(posedge clk);
    model_step(rst, pv, p, rv, rt);
    #1;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, " occupancy"}, int'(occupancy), m_q.size());
    chk({tag, " pred_ready"}, int'(pred_ready), int'(m_q.size() < DEPTH));
    chk({tag, " upd_valid"}, int'(upd_valid), int'(m_uv));
    if (m_uv) chk({tag, " upd_taken"}, int'(upd_taken), int'(m_ut));
    chk({tag, " mispredict"}, int'(mispredict), int'(m_mp));
    chk({tag, " hit_cnt"}, int'(hit_cnt), m_hit);
    chk({tag, " miss_cnt"}, int'(miss_cnt), m_miss);
    chk({tag, " underflow_err"}, int'(underflow_err), int'(m_uf));
  endtask

  typedef struct {
    bit pv, p, rv, rt;
    int occ; bit rdy, uv, ut, mp; int hit, miss; bit uf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit pv, input bit p, input bit rv, input bit rt,
                              input int occ, input bit rdy, input bit uv, input bit ut,
                              input bit mp, input int hit, input int miss, input bit uf);
    vec_t v;
    v.pv = pv; v.p = p; v.rv = rv; v.rt = rt;
    v.occ = occ; v.rdy = rdy; v.uv = uv; v.ut = ut; v.mp = mp;
    v.hit = hit; v.miss = miss; v.uf = uf;
    vecs.push_back(v);
  endfunction

  initial begin
    reset = 1; pred_valid = 0; predict = 0; res_valid = 0; res_taken = 0;

    //   pv p rv rt | occ rdy uv ut mp hit miss uf
    add(0,0,0,0, 0,1,0,0,0, 0,0,0);   // idle x3
    add(0,0,0,0, 0,1,0,0,0, 0,0,0);
    add(0,0,0,0, 0,1,0,0,0, 0,0,0);
    add(1,1,0,0, 1,1,0,0,0, 0,0,0);   // push 1,1,0
    add(1,1,0,0, 2,1,0,0,0, 0,0,0);
    add(1,0,0,0, 3,1,0,0,0, 0,0,0);
    add(0,0,1,1, 2,1,1,1,0, 1,0,0);   // resolve 1,1,0
    add(0,0,1,1, 1,1,1,1,0, 2,0,0);
    add(0,0,1,0, 0,1,1,0,0, 3,0,0);
    add(0,0,0,0, 0,1,0,0,0, 3,0,0);
    add(1,1,0,0, 1,1,0,0,0, 3,0,0);   // fill to DEPTH
    add(1,1,0,0, 2,1,0,0,0, 3,0,0);
    add(1,1,0,0, 3,1,0,0,0, 3,0,0);
    add(1,1,0,0, 4,0,0,0,0, 3,0,0);
    add(1,0,0,0, 4,0,0,0,0, 3,0,0);   // 5th push ignored
    add(0,0,1,1, 3,1,1,1,0, 4,0,0);
    add(0,0,1,1, 2,1,1,1,0, 5,0,0);
    add(0,0,1,1, 1,1,1,1,0, 6,0,0);
    add(0,0,1,1, 0,1,1,1,0, 7,0,0);
    add(1,1,0,0, 1,1,0,0,0, 7,0,0);   // push 1,0,1
    add(1,0,0,0, 2,1,0,0,0, 7,0,0);
    add(1,1,0,0, 3,1,0,0,0, 7,0,0);
    add(0,0,1,0, 0,1,1,0,1, 7,1,0);   // mispredict flushes
    add(0,0,1,1, 0,1,0,0,0, 7,1,1);   // resolve on empty
    add(1,1,0,0, 1,1,0,0,0, 7,1,1);
    add(1,1,0,0, 2,1,0,0,0, 7,1,1);
    add(1,0,1,1, 2,1,1,1,0, 8,1,1);   // push+pop together
    add(0,0,1,1, 1,1,1,1,0, 9,1,1);
    add(0,0,1,0, 0,1,1,0,0, 10,1,1);  // order kept: last is the 0
    add(1,1,0,0, 1,1,0,0,0, 10,1,1);
    add(1,1,1,0, 0,1,1,0,1, 10,2,1);  // push dropped on mispredict
    add(0,0,0,0, 0,1,0,0,0, 10,2,1);

    drive(1,0,0,0,0);
    drive(1,0,0,0,0);
    chk("reset occupancy", int'(occupancy), 0);
    chk("reset upd_taken", int'(upd_taken), 0);
    chk("reset pred_ready", int'(pred_ready), 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(0, vecs[i].pv, vecs[i].p, vecs[i].rv, vecs[i].rt);
      $display("vec %0d: pv=%0b p=%0b rv=%0b rt=%0b -> occ=%0d rdy=%0b uv=%0b ut=%0b mp=%0b hit=%0d miss=%0d uf=%0b",
               i, vecs[i].pv, vecs[i].p, vecs[i].rv, vecs[i].rt, occupancy, pred_ready,
               upd_valid, upd_taken, mispredict, hit_cnt, miss_cnt, underflow_err);
      chk($sformatf("vec%0d occupancy", i), int'(occupancy), vecs[i].occ);
      chk($sformatf("vec%0d pred_ready", i), int'(pred_ready), int'(vecs[i].rdy));
      chk($sformatf("vec%0d upd_valid", i), int'(upd_valid), int'(vecs[i].uv));
      if (vecs[i].uv) chk($sformatf("vec%0d upd_taken", i), int'(upd_taken), int'(vecs[i].ut));
      chk($sformatf("vec%0d mispredict", i), int'(mispredict), int'(vecs[i].mp));
      chk($sformatf("vec%0d hit_cnt", i), int'(hit_cnt), vecs[i].hit);
      chk($sformatf("vec%0d miss_cnt", i), int'(miss_cnt), vecs[i].miss);
      chk($sformatf("vec%0d underflow_err", i), int'(underflow_err), int'(vecs[i].uf));
    end

    // Reset mid-operation with occupancy 3 and hit_cnt 5.
    drive(1,0,0,0,0);
    for (int i = 0; i < 5; i++) begin
      drive(0,1,1,0,0);
      drive(0,0,0,1,1);
    end
    for (int i = 0; i < 3; i++) drive(0,1,0,0,0);
    chk("pre-reset occupancy", int'(occupancy), 3);
    chk("pre-reset hit_cnt", int'(hit_cnt), 5);
    drive(1,0,0,0,0);
    $display("mid reset: occ=%0d hit=%0d uf=%0b", occupancy, hit_cnt, underflow_err);
    chk("mid-reset occupancy", int'(occupancy), 0);
    chk("mid-reset hit_cnt", int'(hit_cnt), 0);
    chk("mid-reset underflow_err", int'(underflow_err), 0);
    drive(0,0,0,1,1);
    $display("resolve after reset: uf=%0b uv=%0b", underflow_err, upd_valid);
    chk("post-reset underflow_err", int'(underflow_err), 1);
    chk("post-reset upd_valid", int'(upd_valid), 0);

    // Saturation of both counters.
    drive(1,0,0,0,0);
    for (int i = 0; i < CMAX + 3; i++) begin
      drive(0,1,1,0,0);
      drive(0,0,0,1,1);
      cmp_model("sat_hit");
      drive(0,1,0,0,0);
      drive(0,0,0,1,1);
      cmp_model("sat_miss");
    end
    $display("saturation: hit=%0d miss=%0d", hit_cnt, miss_cnt);
    chk("hit_cnt saturated", int'(hit_cnt), CMAX);
    chk("miss_cnt saturated", int'(miss_cnt), CMAX);

    // Randomized traffic against the reference model.
    drive(1,0,0,0,0);
    for (int i = 0; i < 600; i++) begin
      bit r, pv, p, rv, rt;
      r  = ($urandom_range(0, 199) == 0);
      pv = ($urandom_range(0, 9) < 6);
      p  = 1'($urandom);
      rv = ($urandom_range(0, 9) < 4);
      rt = ($urandom_range(0, 9) < 7) ? p : 1'($urandom);
      drive(r, pv, p, rv, rt);
      $display("rnd %0d: rst=%0b pv=%0b p=%0b rv=%0b rt=%0b -> occ=%0d uv=%0b mp=%0b hit=%0d miss=%0d uf=%0b",
               i, r, pv, p, rv, rt, occupancy, upd_valid, mispredict, hit_cnt, miss_cnt, underflow_err);
      cmp_model($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
